cnna_mul_arb: RTL and testbench
===============================

CNNA_MUL_ARB -- requirements
Module: cnna_mul_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4; number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter DIN0_W, default 13; signed multiplicand width.
REQ-003 SHALL have parameter DIN1_W, default 5; unsigned multiplier width.
REQ-004 SHALL have parameter DOUT_W, default 13; result width.
REQ-005 SHALL have port ap_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port ap_rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester operand valid.
REQ-008 SHALL have port req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero.
REQ-009 SHALL have port req_din0  input  N_REQ*DIN0_W  packed signed operands, requester i at slice i.
REQ-010 SHALL have port req_din1  input  N_REQ*DIN1_W  packed unsigned operands.
REQ-011 SHALL have port res_valid  output  1  result valid.
REQ-012 SHALL have port res_ready  input  1  downstream accept.
REQ-013 SHALL have port res_dout  output  DOUT_W  signed product.
REQ-014 SHALL have port res_id  output  clog2(N_REQ)  index of the requester that owns res_dout.

Function
REQ-015 SHALL compute din0 (signed) times {1'b0,din1} (non-negative), full product DIN0_W+DIN1_W+1 bits, then reduce to DOUT_W.
REQ-016 SHALL transfer a request when req_valid[i] and req_ready[i] are both high at a rising edge; the result SHALL transfer when res_valid and res_ready are both high.
REQ-017 SHALL assert at most one req_ready bit per cycle, only to a requester with req_valid high, only when the output register is empty or res_ready is high (can_accept).
REQ-018 SHALL arbitrate round-robin: priority starts at pointer ptr and searches upward, wrapping N_REQ-1 -> 0; after a grant to i, ptr <= (i+1) mod N_REQ; ptr SHALL hold when no grant occurs.
REQ-019 SHALL register product and id in a single output stage: a grant at edge t gives res_valid high after edge t (latency 1), sustaining 1 result/cycle when res_ready stays high.
REQ-020 SHALL hold res_valid, res_dout and res_id stable while res_valid and not res_ready.
REQ-021 SHALL clear res_valid after a result transfer with no simultaneous grant; a result transfer and a new grant at the same edge SHALL load the new result with no bubble.
REQ-022 SHALL keep req_ready combinational from req_valid, ptr and output-stage state, with no combinational path from req_din* to req_ready.

Reset
REQ-023 SHALL, while ap_rst is high, drive req_ready = 0, res_valid = 0, res_dout = 0, res_id = 0, and set ptr = 0.
REQ-024 SHALL discard any in-flight result on reset mid-operation; the first grant after reset SHALL go to the lowest-index valid requester.

Configuration
REQ-025 SHALL use macro CNNA_MUL_ARB_SAT_EN: when defined, the product saturates to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]; when undefined, the low DOUT_W bits are kept (two's-complement wrap). Handshake and latency SHALL be identical in both builds.

Structure
REQ-026 SHALL place the width defaults, N_REQ default, id-width function and saturation limits in package cnna_mul_arb_pkg.
REQ-027 SHALL implement round-robin grant and ptr update in sub-module cnna_mul_arb_rr; the multiply, reduction and output register stay in the top level.

Verification
REQ-028 SHALL cover: req 0 only, din0=-5, din1=31, res_ready=1 -> one cycle later res_dout=-155, res_id=0.
REQ-029 SHALL cover: din0=200, din1=31 -> res_dout=-1992 without the macro, 4095 with CNNA_MUL_ARB_SAT_EN.
REQ-030 SHALL cover: all 4 req_valid held high, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, res_id follows the same order one cycle later.
REQ-031 SHALL cover: res_ready=0 for 3 cycles with res_valid high -> req_ready=0, outputs stable; res_ready rises -> result transfers and the next grant issues on the same edge.
REQ-032 SHALL cover: ap_rst pulsed while res_valid=1 and ptr=2 -> res_valid=0 next cycle; requests 1 and 3 valid after reset -> requester 1 granted first.

Source files
------------

// File: rtl/cnna_mul_arb_pkg.sv
// Shared defaults, id-width helper and saturation limits for the shared-multiplier arbiter.
// The optional CNNA_MUL_ARB_SAT_EN build of cnna_mul_arb uses satMax/satMin from here.
package cnna_mul_arb_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DIN0_W = 13;
    localparam int DEF_DIN1_W = 5;
    localparam int DEF_DOUT_W = 13;

    // A single requester id bit is still needed when there are only two requesters.
    function automatic int idWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [63:0] satMax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] satMin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/cnna_mul_arb_rr.sv
// Round-robin grant for the shared multiplier: search starts at r_ptr and wraps,
// r_ptr moves just past the winner and holds when nobody is granted.
module cnna_mul_arb_rr
    import cnna_mul_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_valid,
    input  logic                       i_enable,
    output logic [N_REQ-1:0]           o_grant,
    output logic [idWidth(N_REQ)-1:0]  o_idx
);

    localparam int ID_W = idWidth(N_REQ);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_cand;
    logic [ID_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        o_grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && i_valid[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        if (i_enable && w_found) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    assign o_idx = w_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_enable && w_found) begin
            r_ptr <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cnna_mul_arb.sv
// N requesters share one signed x unsigned multiplier behind a single output register.
// Define CNNA_MUL_ARB_SAT_EN to saturate the product to DOUT_W instead of wrapping.
module cnna_mul_arb
    import cnna_mul_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DIN0_W = DEF_DIN0_W,
    parameter int DIN1_W = DEF_DIN1_W,
    parameter int DOUT_W = DEF_DOUT_W
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DIN0_W-1:0]    req_din0,
    input  logic [N_REQ*DIN1_W-1:0]    req_din1,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DOUT_W-1:0]          res_dout,
    output logic [idWidth(N_REQ)-1:0]  res_id
);

    localparam int ID_W   = idWidth(N_REQ);
    localparam int PROD_W = DIN0_W + DIN1_W + 1;

    logic                     r_valid;
    logic [DOUT_W-1:0]        r_dout;
    logic [ID_W-1:0]          r_id;
    logic                     w_enable;
    logic [N_REQ-1:0]         w_grant;
    logic [ID_W-1:0]          w_idx;
    logic [DIN0_W-1:0]        w_din0;
    logic [DIN1_W-1:0]        w_din1;
    logic signed [PROD_W-1:0] w_a;
    logic signed [PROD_W-1:0] w_b;
    logic signed [PROD_W-1:0] w_prod;
    logic [DOUT_W-1:0]        w_dout;

    // A new operand pair may enter only if the output slot frees up on this edge.
    assign w_enable = (!r_valid || res_ready) && !ap_rst;

    cnna_mul_arb_rr #(
        .N_REQ (N_REQ)
    ) u_rr (
        .i_clk    (ap_clk),
        .i_rst    (ap_rst),
        .i_valid  (req_valid),
        .i_enable (w_enable),
        .o_grant  (w_grant),
        .o_idx    (w_idx)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_din0 = '0;
        w_din1 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_din0 = req_din0[i*DIN0_W +: DIN0_W];
                w_din1 = req_din1[i*DIN1_W +: DIN1_W];
            end
        end
    end

    // din1 is zero-extended by one bit so the product is computed fully signed.
    assign w_a    = PROD_W'($signed(w_din0));
    assign w_b    = PROD_W'($signed({1'b0, w_din1}));
    assign w_prod = w_a * w_b;

`ifdef CNNA_MUL_ARB_SAT_EN
    localparam logic signed [PROD_W-1:0] P_MAX = PROD_W'(satMax(DOUT_W));
    localparam logic signed [PROD_W-1:0] P_MIN = PROD_W'(satMin(DOUT_W));

    always_comb begin
        w_dout = DOUT_W'(w_prod);
        if (w_prod > P_MAX) begin
            w_dout = DOUT_W'(P_MAX);
        end else if (w_prod < P_MIN) begin
            w_dout = DOUT_W'(P_MIN);
        end
    end
`else
    assign w_dout = DOUT_W'(w_prod);
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
            r_id    <= '0;
        end else if (|w_grant) begin
            r_valid <= 1'b1;
            r_dout  <= w_dout;
            r_id    <= w_idx;
        end else if (res_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign res_valid = r_valid;
    assign res_dout  = r_dout;
    assign res_id    = r_id;

endmodule

// File: tb/tb_cnna_mul_arb.sv
// Randomized and directed bench for cnna_mul_arb against a cycle-level reference model.
// Expected products follow the CNNA_MUL_ARB_SAT_EN setting of the build.
module tb_cnna_mul_arb;

    localparam int N_REQ  = 4;
    localparam int DIN0_W = 13;
    localparam int DIN1_W = 5;
    localparam int DOUT_W = 13;
    localparam int ID_W   = 2;

    logic                    ap_clk = 1'b0;
    logic                    ap_rst = 1'b1;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DIN0_W-1:0] req_din0;
    logic [N_REQ*DIN1_W-1:0] req_din1;
    logic                    res_valid;
    logic                    res_ready = 1'b1;
    logic [DOUT_W-1:0]       res_dout;
    logic [ID_W-1:0]         res_id;

    logic signed [DIN0_W-1:0] din0Arr [N_REQ];
    logic        [DIN1_W-1:0] din1Arr [N_REQ];

    int     nChecks = 0;
    int     nErrors = 0;

    int     mPtr   = 0;
    int     mValid = 0;
    longint mDout  = 0;
    int     mId    = 0;

    cnna_mul_arb dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_dout  (res_dout),
        .res_id    (res_id)
    );

    always #5 ap_clk = ~ap_clk;

    always_comb begin
        req_din0 = '0;
        req_din1 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_din0[i*DIN0_W +: DIN0_W] = din0Arr[i];
            req_din1[i*DIN1_W +: DIN1_W] = din1Arr[i];
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Product as plain integer arithmetic, then saturated or wrapped to DOUT_W.
    function automatic longint refProduct(input longint a, input longint b);
        longint p;
        longint m;
        p = a * b;
        m = longint'(1) << DOUT_W;
`ifdef CNNA_MUL_ARB_SAT_EN
        if (p > (m / 2) - 1) p = (m / 2) - 1;
        if (p < -(m / 2))    p = -(m / 2);
`else
        p = ((p % m) + m) % m;
        if (p >= m / 2) p = p - m;
`endif
        return p;
    endfunction

    function automatic int modelGrant();
        if (ap_rst) return -1;
        if (mValid != 0 && !res_ready) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (req_valid[(mPtr + k) % N_REQ]) return (mPtr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [N_REQ-1:0] valid, input logic rdy);
        ap_rst    = rst;
        req_valid = valid;
        res_ready = rdy;
        #1;
    endtask

    // Compare every output against the model mid-cycle, then advance one edge.
    task automatic stepCycle();
        int g;
        longint expReady;
        @(negedge ap_clk);
        g = modelGrant();
        expReady = (g >= 0) ? (longint'(1) << g) : 0;
        checkOutput("req_ready", longint'(req_ready), expReady);
        checkOutput("res_valid", longint'(res_valid), longint'(mValid));
        checkOutput("res_dout", longint'($signed(res_dout)), mDout);
        checkOutput("res_id", longint'(res_id), longint'(mId));
        @(posedge ap_clk);
        if (ap_rst) begin
            mValid = 0; mDout = 0; mId = 0; mPtr = 0;
        end else if (g >= 0) begin
            mValid = 1;
            mDout  = refProduct(longint'(din0Arr[g]), longint'(din1Arr[g]));
            mId    = g;
            mPtr   = (g + 1) % N_REQ;
        end else if (res_ready) begin
            mValid = 0;
        end
        #1;
    endtask

    initial begin
        logic [DOUT_W-1:0] heldDout;
        logic [ID_W-1:0]   heldId;
        for (int i = 0; i < N_REQ; i++) begin
            din0Arr[i] = '0;
            din1Arr[i] = '0;
        end

        // Reset state, with requests pending that must not be granted.
        applyStimulus(1'b1, 4'hF, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("rst_ready", longint'(req_ready), 0);
        checkOutput("rst_valid", longint'(res_valid), 0);
        checkOutput("rst_dout", longint'(res_dout), 0);
        checkOutput("rst_id", longint'(res_id), 0);

        // Single requester, negative operand.
        din0Arr[0] = -13'sd5;
        din1Arr[0] = 5'd31;
        applyStimulus(1'b0, 4'b0001, 1'b1);
        checkOutput("neg_ready", longint'(req_ready), 1);
        stepCycle();
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("neg_dout", longint'($signed(res_dout)), -155);
        checkOutput("neg_id", longint'(res_id), 0);
        checkOutput("neg_valid", longint'(res_valid), 1);

        // Overflowing product.
        din0Arr[0] = 13'sd200;
        applyStimulus(1'b0, 4'b0001, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 4'b0000, 1'b1);
`ifdef CNNA_MUL_ARB_SAT_EN
        checkOutput("ovf_dout", longint'($signed(res_dout)), 4095);
`else
        checkOutput("ovf_dout", longint'($signed(res_dout)), -1992);
`endif
        stepCycle();
        checkOutput("drain_valid", longint'(res_valid), 0);

        // Round-robin order with every requester busy.
        applyStimulus(1'b1, 4'h0, 1'b1);
        stepCycle();
        for (int i = 0; i < N_REQ; i++) begin
            din0Arr[i] = DIN0_W'(i * 7 - 11);
            din1Arr[i] = DIN1_W'(i + 3);
        end
        applyStimulus(1'b0, 4'hF, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checkOutput("rr_ready", longint'(req_ready), longint'(1) << (k % 4));
            stepCycle();
            checkOutput("rr_id", longint'(res_id), k % 4);
        end

        // Back-pressure: nothing granted and outputs frozen while stalled.
        applyStimulus(1'b0, 4'hF, 1'b0);
        heldDout = res_dout;
        heldId   = res_id;
        for (int k = 0; k < 3; k++) begin
            checkOutput("stall_ready", longint'(req_ready), 0);
            stepCycle();
            checkOutput("stall_valid", longint'(res_valid), 1);
            checkOutput("stall_dout", longint'(res_dout), longint'(heldDout));
            checkOutput("stall_id", longint'(res_id), longint'(heldId));
        end
        applyStimulus(1'b0, 4'hF, 1'b1);
        checkOutput("resume_ready", longint'(req_ready), 4);
        stepCycle();
        checkOutput("resume_id", longint'(res_id), 2);
        checkOutput("resume_valid", longint'(res_valid), 1);

        // Reset mid-operation with the pointer away from zero.
        applyStimulus(1'b1, 4'h0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 4'b0011, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("pre_rst_valid", longint'(res_valid), 1);
        checkOutput("pre_rst_id", longint'(res_id), 1);
        applyStimulus(1'b1, 4'hF, 1'b1);
        checkOutput("mid_rst_ready", longint'(req_ready), 0);
        stepCycle();
        checkOutput("mid_rst_valid", longint'(res_valid), 0);
        applyStimulus(1'b0, 4'b1010, 1'b1);
        checkOutput("post_rst_ready", longint'(req_ready), 2);
        stepCycle();
        checkOutput("post_rst_id", longint'(res_id), 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                din0Arr[i] = DIN0_W'($urandom);
                din1Arr[i] = DIN1_W'($urandom);
            end
            applyStimulus($urandom_range(0, 99) == 0, N_REQ'($urandom), $urandom_range(0, 9) < 7);
            stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
